// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo sweep controller.
package servo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SWEEP_UP   = 2'd1,
        ST_SWEEP_DOWN = 2'd2,
        ST_HOMING     = 2'd3
    } servo_state_t;

    localparam logic [1:0] MODE_SWEEP    = 2'd0;
    localparam logic [1:0] MODE_HOLD     = 2'd1;
    localparam logic [1:0] MODE_HOME     = 2'd2;
    localparam logic [1:0] MODE_HOLD_ALT = 2'd3;

    // Limits must leave room for +/-1 so duty arithmetic never wraps.
    function automatic bit duty_params_ok(input int duty_w, input int dmin,
                                          input int dhome, input int dmax);
        return (dmin > 0) && (dmin < dhome) && (dhome < dmax) &&
               (dmax < (1 << duty_w) - 1);
    endfunction

endpackage

// File: rtl/servo_pwm_timebase.sv
// Shared PWM timebase: step prescaler, frame phase counter and sweep step tick.
module servo_pwm_timebase #(
    parameter int DUTY_W   = 9,
    parameter int PWM_DIV  = 3906,
    parameter int STEP_DIV = 4194304
) (
    input  logic              clk,
    input  logic              reset_p,
    output logic [DUTY_W-1:0] phase,
    output logic              frame,
    output logic              stick
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int STK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);
    localparam logic [STK_W-1:0] STK_LAST = STK_W'(STEP_DIV - 1);

    logic [PRE_W-1:0]  pre_reg;
    logic [STK_W-1:0]  stk_reg;
    logic [DUTY_W-1:0] phase_reg;
    logic              ptick;

    assign ptick = (pre_reg == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            pre_reg   <= '0;
            stk_reg   <= '0;
            phase_reg <= '0;
        end else begin
            pre_reg <= ptick ? '0 : pre_reg + 1'b1;
            stk_reg <= stick ? '0 : stk_reg + 1'b1;
            if (ptick) begin
                phase_reg <= phase_reg + 1'b1;
            end
        end
    end

    assign phase = phase_reg;
    // High in the last step of a frame: the edge ending it wraps phase to 0.
    assign frame = ptick && (phase_reg == '1);
    assign stick = (stk_reg == STK_LAST);

endmodule

// File: rtl/servo_sweep_ctrl.sv
// Multi-channel hobby-servo sweep/hold/home controller on a shared 50 Hz PWM frame.
module servo_sweep_ctrl
    import servo_pkg::*;
#(
    parameter int CH        = 2,
    parameter int DUTY_W    = 9,
    parameter int PWM_DIV   = 3906,
    parameter int STEP_DIV  = 4194304,
    parameter int DUTY_MIN  = 8,
    parameter int DUTY_MAX  = 70,
    parameter int DUTY_HOME = 14
) (
    input  logic                 clk,
    input  logic                 reset_p,
    input  logic                 motor_en,
    input  logic [CH-1:0]        start_pe,
    input  logic [2*CH-1:0]      mode,
    output logic [CH-1:0]        pwm,
    output logic [DUTY_W*CH-1:0] duty_out,
    output logic [CH-1:0]        busy,
    output logic [CH-1:0]        home_done
);

    localparam logic [DUTY_W-1:0] D_MIN  = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] D_MAX  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] D_HOME = DUTY_W'(DUTY_HOME);

    generate
        if (!duty_params_ok(DUTY_W, DUTY_MIN, DUTY_HOME, DUTY_MAX)) begin : g_bad_params
            $error("servo_sweep_ctrl: need 0 < DUTY_MIN < DUTY_HOME < DUTY_MAX < 2**DUTY_W-1");
        end
    endgenerate

    logic [DUTY_W-1:0] phase;
    logic              frame;
    logic              stick;

    servo_pwm_timebase #(
        .DUTY_W   (DUTY_W),
        .PWM_DIV  (PWM_DIV),
        .STEP_DIV (STEP_DIV)
    ) u_timebase (
        .clk     (clk),
        .reset_p (reset_p),
        .phase   (phase),
        .frame   (frame),
        .stick   (stick)
    );

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        servo_state_t      state_reg;
        logic [DUTY_W-1:0] duty_w_reg;
        logic [DUTY_W-1:0] duty_a_reg;
        logic              pwm_reg;
        logic              busy_reg;
        logic              home_done_reg;
        logic [1:0]        ch_mode;
        logic              is_hold;

        assign ch_mode = mode[2*gi +: 2];
        assign is_hold = (ch_mode == MODE_HOLD) || (ch_mode == MODE_HOLD_ALT);

        always_ff @(posedge clk) begin
            if (reset_p) begin
                state_reg     <= ST_IDLE;
                duty_w_reg    <= D_HOME;
                duty_a_reg    <= D_HOME;
                pwm_reg       <= 1'b0;
                busy_reg      <= 1'b0;
                home_done_reg <= 1'b0;
            end else begin
                home_done_reg <= 1'b0;
                pwm_reg       <= (phase < duty_a_reg);
                if (frame) begin
                    duty_a_reg <= duty_w_reg;
                end

                // Transitions pre-empt stepping, so a coincident stick is dropped.
                if (!motor_en) begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end else if (start_pe[gi]) begin
                    if (state_reg != ST_IDLE) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (ch_mode == MODE_SWEEP) begin
                        state_reg <= ST_SWEEP_UP;
                        busy_reg  <= 1'b1;
                    end else if (ch_mode == MODE_HOME) begin
                        state_reg <= ST_HOMING;
                        busy_reg  <= 1'b1;
                    end
                end else begin
                    case (state_reg)
                        ST_SWEEP_UP, ST_SWEEP_DOWN: begin
                            if (is_hold) begin
                                state_reg <= ST_IDLE;
                                busy_reg  <= 1'b0;
                            end else if (ch_mode == MODE_HOME) begin
                                state_reg <= ST_HOMING;
                            end else if (stick) begin
                                if (state_reg == ST_SWEEP_UP) begin
                                    if (duty_w_reg >= D_MAX) begin
                                        duty_w_reg <= duty_w_reg - 1'b1;
                                        state_reg  <= ST_SWEEP_DOWN;
                                    end else begin
                                        duty_w_reg <= duty_w_reg + 1'b1;
                                    end
                                end else begin
                                    if (duty_w_reg <= D_MIN) begin
                                        duty_w_reg <= duty_w_reg + 1'b1;
                                        state_reg  <= ST_SWEEP_UP;
                                    end else begin
                                        duty_w_reg <= duty_w_reg - 1'b1;
                                    end
                                end
                            end
                        end
                        ST_HOMING: begin
                            if (stick) begin
                                if (duty_w_reg == D_HOME) begin
                                    state_reg     <= ST_IDLE;
                                    busy_reg      <= 1'b0;
                                    home_done_reg <= 1'b1;
                                end else if (duty_w_reg < D_HOME) begin
                                    duty_w_reg <= duty_w_reg + 1'b1;
                                end else begin
                                    duty_w_reg <= duty_w_reg - 1'b1;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end

        assign pwm[gi]                          = pwm_reg;
        assign busy[gi]                         = busy_reg;
        assign home_done[gi]                    = home_done_reg;
        assign duty_out[gi*DUTY_W +: DUTY_W]    = duty_a_reg;
    end

endmodule

// File: tb/tb_servo_sweep_ctrl.sv
// Scoreboard bench for servo_sweep_ctrl: directed scenarios then random stimulus vs a behavioural model.
module tb_servo_sweep_ctrl;

    localparam int CH    = 2;
    localparam int DW    = 4;
    localparam int PD    = 1;
    localparam int SD    = 4;
    localparam int DMIN  = 2;
    localparam int DHOME = 4;
    localparam int DMAX  = 8;
    localparam int FRAME = 16;

    logic              clk = 1'b0;
    logic              reset_p;
    logic              motor_en;
    logic [CH-1:0]     start_pe;
    logic [2*CH-1:0]   mode;
    logic [CH-1:0]     pwm;
    logic [DW*CH-1:0]  duty_out;
    logic [CH-1:0]     busy;
    logic [CH-1:0]     home_done;

    always #5 clk = ~clk;

    servo_sweep_ctrl #(
        .CH(CH), .DUTY_W(DW), .PWM_DIV(PD), .STEP_DIV(SD),
        .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .DUTY_HOME(DHOME)
    ) dut (
        .clk(clk), .reset_p(reset_p), .motor_en(motor_en), .start_pe(start_pe),
        .mode(mode), .pwm(pwm), .duty_out(duty_out), .busy(busy), .home_done(home_done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // run: 0 idle, 1 sweeping, 2 homing. t counts clocks since reset release.
    typedef struct packed {
        logic [CH-1:0] pwm;
        logic [CH-1:0] busy;
    } cyc_t;
    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] val;
    } devt_t;

    int    t;
    int    run [CH];
    bit    up  [CH];
    int    pos [CH];
    int    act [CH];
    bit    mon_on = 1'b0;
    cyc_t  cyc_q[$];
    devt_t duty_q[$];
    int    hd_q[$];
    int    hd_cnt0 = 0;

    task automatic push_duty(input int c, input int v);
        devt_t ev;
        ev.ch  = 8'(c);
        ev.val = 8'(v);
        duty_q.push_back(ev);
    endtask

    // Position bounces between the limits like a ball, one unit per tick.
    task automatic sweep_step(input int c);
        if (up[c]) begin
            if (pos[c] >= DMAX) begin up[c] = 1'b0; pos[c]--; end
            else pos[c]++;
        end else begin
            if (pos[c] <= DMIN) begin up[c] = 1'b1; pos[c]++; end
            else pos[c]--;
        end
    endtask

    task automatic model_edge();
        cyc_t e;
        int   ph;
        int   m;
        bit   stk;
        bit   frm;
        e = '0;
        if (reset_p) begin
            t = 0;
            for (int c = 0; c < CH; c++) begin
                run[c] = 0;
                up[c]  = 1'b1;
                pos[c] = DHOME;
                if (act[c] != DHOME) push_duty(c, DHOME);
                act[c] = DHOME;
            end
        end else begin
            ph  = t % FRAME;
            stk = ((t % SD) == SD - 1);
            frm = (ph == FRAME - 1);
            for (int c = 0; c < CH; c++) begin
                m = int'(mode[2*c +: 2]);
                e.pwm[c] = (ph < act[c]);
                if (frm && act[c] != pos[c]) begin
                    act[c] = pos[c];
                    push_duty(c, pos[c]);
                end
                if (!motor_en) begin
                    run[c] = 0;
                end else if (start_pe[c]) begin
                    if (run[c] != 0) run[c] = 0;
                    else if (m == 0) begin run[c] = 1; up[c] = 1'b1; end
                    else if (m == 2) run[c] = 2;
                end else if (run[c] == 1) begin
                    if (m == 1 || m == 3) run[c] = 0;
                    else if (m == 2) run[c] = 2;
                    else if (stk) sweep_step(c);
                end else if (run[c] == 2 && stk) begin
                    if (pos[c] == DHOME) begin
                        run[c] = 0;
                        hd_q.push_back(c);
                    end else begin
                        pos[c] += (pos[c] < DHOME) ? 1 : -1;
                    end
                end
                e.busy[c] = (run[c] != 0);
            end
            t++;
        end
        if (mon_on) cyc_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit               first = 1'b1;
        logic [DW*CH-1:0] last  = '0;
        cyc_t             e;
        devt_t            ev;
        int               dv;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (first) begin
                    last  = duty_out;
                    first = 1'b0;
                end
                while (cyc_q.size() > 0) begin
                    e = cyc_q.pop_front();
                    check("pwm_busy", int'({pwm, busy}), int'({e.pwm, e.busy}));
                end
                for (int c = 0; c < CH; c++) begin
                    if (duty_out[c*DW +: DW] != last[c*DW +: DW]) begin
                        dv = int'(duty_out[c*DW +: DW]);
                        if (duty_q.size() == 0) begin
                            check("duty_evt_unexpected(ch*256+duty)", c*256 + dv, -1);
                        end else begin
                            ev = duty_q.pop_front();
                            check("duty_evt(ch*256+duty)", c*256 + dv, int'(ev.ch)*256 + int'(ev.val));
                        end
                    end
                    if (home_done[c]) begin
                        if (c == 0) hd_cnt0++;
                        if (hd_q.size() == 0) check("home_done_unexpected_ch", c, -1);
                        else check("home_done_ch", c, hd_q.pop_front());
                    end
                end
                last = duty_out;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wait_pos(input int c, input int p, input int dir, input string name);
        int n = 0;
        while (!(pos[c] == p && run[c] == 1 && (dir < 0 || int'(up[c]) == dir)) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check(name, pos[c], p);
    endtask

    task automatic pulse_start(input logic [CH-1:0] s);
        start_pe = s;
        tick();
        start_pe = '0;
    endtask

    initial begin
        int cnt0;
        int cnt1;
        int n;
        reset_p  = 1'b1;
        motor_en = 1'b1;
        start_pe = '0;
        mode     = '0;
        t        = 0;
        for (int c = 0; c < CH; c++) begin
            run[c] = 0; up[c] = 1'b1; pos[c] = DHOME; act[c] = DHOME;
        end

        // 1. reset
        tick();
        mon_on = 1'b1;
        tick();
        tick();
        check("rst_duty_out", int'(duty_out), 8'h44);
        check("rst_pwm", int'(pwm), 0);
        check("rst_busy", int'(busy), 0);
        reset_p = 1'b0;
        cnt0 = 0;
        cnt1 = 0;
        repeat (FRAME) begin
            tick();
            cnt0 += int'(pwm[0]);
            cnt1 += int'(pwm[1]);
        end
        check("pwm0_high_per_frame", cnt0, 4);
        check("pwm1_high_per_frame", cnt1, 4);

        // 2./3. sweep ch0 with bounce, frame-aligned apply
        pulse_start(2'b01);
        check("busy_after_start", int'(busy), 1);
        repeat (120) tick();
        check("ch1_duty_unchanged", int'(duty_out[DW +: DW]), DHOME);

        // 4. stop at 7, then home
        wait_pos(0, 7, -1, "wait_pos7");
        pulse_start(2'b01);
        check("stop_busy", int'(busy[0]), 0);
        mode[1:0] = 2'd2;
        tick();
        check("mode_change_idle_busy", int'(busy[0]), 0);
        hd_cnt0 = 0;
        pulse_start(2'b01);
        check("homing_busy", int'(busy[0]), 1);
        n = 0;
        while (run[0] != 0 && n < 64) begin tick(); n++; end
        if (n >= 64) check("homing_timeout", run[0], 0);
        repeat (FRAME + 4) tick();
        check("home_done_pulses", hd_cnt0, 1);
        check("homed_busy", int'(busy[0]), 0);
        check("homed_duty", int'(duty_out[DW-1:0]), DHOME);

        // 5. motor_en low beats start_pe
        mode     = '0;
        motor_en = 1'b0;
        start_pe = 2'b10;
        tick();
        start_pe = '0;
        motor_en = 1'b1;
        check("prio_busy", int'(busy[1]), 0);
        repeat (FRAME + 4) tick();
        check("prio_duty", int'(duty_out[DW +: DW]), DHOME);

        // motor_en low while sweeping stops the channel
        pulse_start(2'b01);
        repeat (10) tick();
        motor_en = 1'b0;
        tick();
        check("disable_busy", int'(busy), 0);
        motor_en = 1'b1;

        // 6. reset mid sweep-down at duty 6
        pulse_start(2'b01);
        wait_pos(0, 6, 0, "wait_pos6_down");
        reset_p = 1'b1;
        tick();
        check("midrst_busy", int'(busy), 0);
        check("midrst_duty_out", int'(duty_out), 8'h44);
        check("midrst_pwm", int'(pwm), 0);
        reset_p = 1'b0;
        repeat (2 * FRAME) tick();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < CH; c++) begin
                start_pe[c] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 31) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
            end
            motor_en = ($urandom_range(0, 63) != 0);
            reset_p  = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset_p  = 1'b0;
        motor_en = 1'b1;
        start_pe = '0;
        repeat (4) tick();
        check("cyc_q_drained", cyc_q.size(), 0);
        check("duty_q_drained", duty_q.size(), 0);
        check("hd_q_drained", hd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
